bus_mux_reg: RTL
================

# bus_mux_reg

Registered, parametrised successor to the datapath bus multiplexer. It takes one-hot drive enables from up to NSRC sources (register file, HI/LO, Z, PC, MDR, In.Port, C sign-extended, Y, …) and forwards the selected word onto the internal bus through one pipeline register. It also reports which source drove the bus and flags multiple-driver conflicts, and it keeps a transfer count for control-unit debug. It sits between the datapath sources and every bus consumer.

## Interface
- WIDTH, 32, bus word width in bits
- NSRC, 25, number of bus sources (2..32)
- SELW, 5, width of source index; must satisfy 2**SELW >= NSRC
- HOLD_IDLE, 1, 1: bus_out holds last value when no source enabled; 0: bus_out clears to 0
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- src_en  in  NSRC  one-hot drive enables; bit i = source i drives the bus
- src_data  in  NSRC*WIDTH  flattened source words; source i at bits [i*WIDTH +: WIDTH]
- stall  in  1  1 = freeze all state; inputs ignored
- conflict_ack  in  1  clears conflict_sticky
- bus_out  out  WIDTH  registered bus word
- bus_valid  out  1  bus_out was captured from a source on the last accepted cycle
- bus_sel  out  SELW  index of the source captured into bus_out
- conflict  out  1  one-cycle pulse: more than one enable on the last accepted cycle
- conflict_sticky  out  1  latched conflict, held until acknowledged
- xfer_count  out  16  saturating count of valid captures

## Operation
- Reset (clr=0, asynchronous): bus_out=0, bus_valid=0, bus_sel=0, conflict=0, conflict_sticky=0, xfer_count=0.
- An accepted cycle is any rising edge with clr=1 and stall=0. Per accepted cycle, with k = popcount(src_en):
  - k=1: bus_out <= src_data of the enabled source i; bus_sel <= i; bus_valid <= 1; conflict <= 0.
  - k=0: bus_valid <= 0; conflict <= 0; bus_sel holds. With HOLD_IDLE=1, bus_out holds; with HOLD_IDLE=0, bus_out <= 0.
  - k>=2: the lowest-index enabled source wins (fixed priority). bus_out and bus_sel take that source; bus_valid <= 1; conflict <= 1; conflict_sticky <= 1.
- Enable bits at index >= NSRC do not exist. src_data is ignored for disabled sources.
- xfer_count increments by 1 on every accepted cycle with k>=1. It saturates at 16'hFFFF and does not wrap. Only reset clears it.
- conflict_sticky: the set condition (k>=2 on an accepted cycle) has priority over conflict_ack in the same cycle. conflict_ack with no set clears the flag next edge. conflict_ack is honoured even while stall=1.
- Stall (stall=1): bus_out, bus_valid, bus_sel and xfer_count hold. conflict is forced to 0. conflict_sticky holds, except for conflict_ack.
- No combinational path from inputs to outputs.

## Timing
- Latency 1 cycle: enables and data sampled at edge N appear on the outputs after edge N. Throughput is 1 word per cycle.
- conflict is high for exactly one cycle per conflicting accepted cycle. Back-to-back conflicts keep it high continuously.
- Reset asserted mid-stream clears all outputs immediately, with no clock needed. The first capture after release happens on the first accepted edge with clr=1.
- Stall is level-sensitive. Deasserting stall makes the next edge accepted; nothing is replayed.

## Test plan
- Reset: drive clr=0 with random inputs; all outputs read 0 asynchronously. Release clr; with no enables, outputs stay 0.
- Single source sweep (NSRC=25, WIDTH=32): for i=0..24 assert src_en=1<<i with data 32'hA000_0000+i. One cycle later, bus_out=32'hA000_0000+i, bus_sel=i, bus_valid=1, conflict=0. xfer_count reaches 25.
- Conflict: src_en with bits 3 and 7 set, data3=32'h1111_1111, data7=32'h7777_7777. Next cycle: bus_out=32'h1111_1111, bus_sel=3, conflict=1, sticky=1. Then with k=1, conflict=0 and sticky stays 1. conflict_ack together with a new conflict leaves sticky=1. conflict_ack alone clears it.
- Idle modes: capture 32'hDEAD_BEEF from source 5, then src_en=0. With HOLD_IDLE=1, bus_out stays 32'hDEAD_BEEF, bus_valid=0, bus_sel=5. With HOLD_IDLE=0, bus_out=0.
- Stall: capture source 2, then assert stall for 3 cycles with src_en=1<<9. Outputs and xfer_count are unchanged. Deassert stall; one cycle later bus_sel=9.
- Saturation: force xfer_count to 16'hFFFE by running 65534 transfers, then apply 3 more. Count reads 16'hFFFF and stays there. Asserting clr returns it to 0.

Source files
------------

// File: rtl/bus_mux_reg_if.sv
// Bus-source bundle for bus_mux_reg: source enables and words in,
// registered bus word, source index, conflict flags and transfer count out.
interface bus_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 25,
    parameter int SELW  = 5
);
    logic [NSRC-1:0]       src_en;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  stall;
    logic                  conflict_ack;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SELW-1:0]       bus_sel;
    logic                  conflict;
    logic                  conflict_sticky;
    logic [15:0]           xfer_count;

    // Datapath side: drives sources and control, observes the bus
    modport master (
        output src_en, src_data, stall, conflict_ack,
        input  bus_out, bus_valid, bus_sel, conflict, conflict_sticky, xfer_count
    );

    // Multiplexer side
    modport slave (
        input  src_en, src_data, stall, conflict_ack,
        output bus_out, bus_valid, bus_sel, conflict, conflict_sticky, xfer_count
    );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered internal-bus multiplexer: fixed-priority selection of one of
// NSRC one-hot sources into a single output register, with source index,
// multi-driver conflict detection and a saturating transfer counter.
module bus_mux_reg #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 25,
    parameter int SELW      = 5,
    parameter bit HOLD_IDLE = 1'b1
) (
    input  logic          clk,
    input  logic          clr,
    bus_mux_reg_if.slave  bus
);

    logic [WIDTH-1:0] bus_out_q,   bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic [SELW-1:0]  bus_sel_q,   bus_sel_d;
    logic             conflict_q,  conflict_d;
    logic             sticky_q,    sticky_d;
    logic [15:0]      count_q,     count_d;

    logic             any_en;
    logic             multi_en;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;

    // Counter stops at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Source decode: any driver, more than one driver, lowest-index winner
    always_comb begin
        any_en   = |bus.src_en;
        // Clearing the lowest set bit leaves something only if two or more were set
        multi_en = |(bus.src_en & (bus.src_en - NSRC'(1)));
        win_idx  = '0;
        win_data = '0;
        // Descending scan so the lowest enabled index is the last to write
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.src_en[i]) begin
                win_idx  = SELW'(i);
                win_data = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: capture on accepted cycles, hold everything while stalled
    always_comb begin
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        bus_sel_d   = bus_sel_q;
        count_d     = count_q;
        conflict_d  = 1'b0;
        if (!bus.stall) begin
            conflict_d = multi_en;
            if (any_en) begin
                bus_out_d   = win_data;
                bus_sel_d   = win_idx;
                bus_valid_d = 1'b1;
                count_d     = sat_inc(count_q);
            end else begin
                bus_valid_d = 1'b0;
                if (!HOLD_IDLE) begin
                    bus_out_d = '0;
                end
            end
        end
        // A new conflict beats the acknowledge; the ack still works under stall
        if (!bus.stall && multi_en) begin
            sticky_d = 1'b1;
        end else if (bus.conflict_ack) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_sel_q   <= '0;
            conflict_q  <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_sel_q   <= bus_sel_d;
            conflict_q  <= conflict_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign bus.bus_out         = bus_out_q;
    assign bus.bus_valid       = bus_valid_q;
    assign bus.bus_sel         = bus_sel_q;
    assign bus.conflict        = conflict_q;
    assign bus.conflict_sticky = sticky_q;
    assign bus.xfer_count      = count_q;

endmodule
